// File: rtl/seq_subtractor.sv
// Digit-serial subtractor: difference = A - B - BIn, DIGIT bits per clock, LSB digit first.
// Borrow ripples between digits through a registered flop.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; result and flags of last op are held
// RUN   | one digit per edge, counter selects digit k
// DONE  | single cycle, done=1; start here is accepted back-to-back
module seq_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIn,
    input  logic             is_signed,
    output logic [WIDTH-1:0] difference,
    output logic             BOut,
    output logic             overflow,
    output logic             zero,
    output logic             done
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int MSB  = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    int               digit_lsb;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic [DIGIT:0]   sub;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        borrow_d  = borrow_q;
        a_d       = a_q;
        b_d       = b_q;
        signed_d  = signed_q;
        diff_d    = diff_q;
        bout_d    = bout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;

        digit_lsb = int'(cnt_q) * DIGIT;
        a_dig     = a_q[digit_lsb +: DIGIT];
        b_dig     = b_q[digit_lsb +: DIGIT];
        sub       = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, borrow_q};

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    signed_d = is_signed;
                    borrow_d = BIn;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                diff_d[digit_lsb +: DIGIT] = sub[DIGIT-1:0];
                borrow_d = sub[DIGIT];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(NDIG - 1)) begin
                    // Flags are taken from the fully assembled result on the last digit.
                    state_d = DONE;
                    cnt_d   = '0;
                    bout_d  = sub[DIGIT];
                    zero_d  = (diff_d == '0);
                    ovf_d   = signed_q ? ((a_q[MSB] != b_q[MSB]) && (diff_d[MSB] != a_q[MSB]))
                                       : sub[DIGIT];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign ready      = (state_q != RUN);
    assign done       = (state_q == DONE);
    assign difference = diff_q;
    assign BOut       = bout_q;
    assign overflow   = ovf_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_seq_subtractor.sv
// Randomized and directed checks of seq_subtractor against an arithmetic reference model,
// covering DIGIT=4 (main), DIGIT=1 and DIGIT=16 instances.
module tb_seq_subtractor;

    logic        clk;
    logic        reset_n;
    logic [15:0] op_a, op_b;
    logic        op_bin, op_sgn;
    logic        start_v [3];
    logic        ready_v [3];
    logic [15:0] diff_v  [3];
    logic        bout_v  [3];
    logic        ovf_v   [3];
    logic        zero_v  [3];
    logic        done_v  [3];

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .ready(ready_v[0]),
        .A(op_a), .B(op_b), .BIn(op_bin), .is_signed(op_sgn),
        .difference(diff_v[0]), .BOut(bout_v[0]), .overflow(ovf_v[0]),
        .zero(zero_v[0]), .done(done_v[0]));

    seq_subtractor #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .ready(ready_v[1]),
        .A(op_a), .B(op_b), .BIn(op_bin), .is_signed(op_sgn),
        .difference(diff_v[1]), .BOut(bout_v[1]), .overflow(ovf_v[1]),
        .zero(zero_v[1]), .done(done_v[1]));

    seq_subtractor #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .ready(ready_v[2]),
        .A(op_a), .B(op_b), .BIn(op_bin), .is_signed(op_sgn),
        .difference(diff_v[2]), .BOut(bout_v[2]), .overflow(ovf_v[2]),
        .zero(zero_v[2]), .done(done_v[2]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Plain integer arithmetic: the true mathematical difference decides borrow and overflow.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                                  input logic sgn, output logic [15:0] ed, output logic eb,
                                  output logic eo, output logic ez);
        longint ur, sr;
        ur = longint'(a) - longint'(b) - longint'(bin);
        sr = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        ed = ur[15:0];
        eb = (ur < 0);
        eo = sgn ? ((sr < -32768) || (sr > 32767)) : eb;
        ez = (ed == 16'h0000);
    endfunction

    function automatic int ndig_of(input int which);
        return (which == 0) ? 4 : ((which == 1) ? 16 : 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation; returns while the DUT is in its DONE cycle.
    task automatic run_op(input int which, input logic [15:0] a, input logic [15:0] b,
                          input logic bin, input logic sgn, input bit hold_start,
                          input bit scramble);
        logic [15:0] ed;
        logic        eb, eo, ez;
        int          ndig, cyc, lowc;
        ndig = ndig_of(which);
        model(a, b, bin, sgn, ed, eb, eo, ez);
        check_eq("ready_before_start", 32'(ready_v[which]), 32'd1);
        op_a = a; op_b = b; op_bin = bin; op_sgn = sgn;
        start_v[which] = 1'b1;
        tick();
        if (!hold_start) start_v[which] = 1'b0;
        if (scramble) begin
            op_a = 16'($urandom); op_b = 16'($urandom); op_bin = ~bin; op_sgn = ~sgn;
        end
        cyc = 0;
        lowc = 0;
        while (!done_v[which] && cyc < 40) begin
            if (!ready_v[which]) lowc++;
            tick();
            cyc++;
        end
        start_v[which] = 1'b0;
        check_eq("latency", 32'(cyc), 32'(ndig));
        check_eq("ready_low_cycles", 32'(lowc), 32'(ndig));
        check_eq("difference", 32'(diff_v[which]), 32'(ed));
        check_eq("bout", 32'(bout_v[which]), 32'(eb));
        check_eq("overflow", 32'(ovf_v[which]), 32'(eo));
        check_eq("zero", 32'(zero_v[which]), 32'(ez));
        check_eq("ready_in_done", 32'(ready_v[which]), 32'd1);
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_diff"},  32'(diff_v[0]),  32'd0);
        check_eq({tag, "_bout"},  32'(bout_v[0]),  32'd0);
        check_eq({tag, "_ovf"},   32'(ovf_v[0]),   32'd0);
        check_eq({tag, "_zero"},  32'(zero_v[0]),  32'd0);
        check_eq({tag, "_ready"}, 32'(ready_v[0]), 32'd1);
        check_eq({tag, "_done"},  32'(done_v[0]),  32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int done_seen;
        reset_n = 1'b0;
        op_a = '0; op_b = '0; op_bin = 1'b0; op_sgn = 1'b0;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        check_cleared("reset");
        tick();

        run_op(0, 16'h1234, 16'h0234, 1'b0, 1'b0, 0, 0);
        tick();
        run_op(0, 16'h0000, 16'h0001, 1'b0, 1'b0, 0, 0);
        tick();
        run_op(0, 16'h0000, 16'h0001, 1'b0, 1'b1, 0, 0);
        tick();
        run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 0, 0);
        tick();
        run_op(0, 16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 0, 0);
        tick();
        run_op(0, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 0, 0);
        tick();
        run_op(0, 16'h0005, 16'h0004, 1'b1, 1'b0, 0, 0);
        tick();

        // start held through RUN with inputs scrambled, then back-to-back from DONE
        run_op(0, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1, 1);
        run_op(0, 16'h0010, 16'h0001, 1'b0, 1'b0, 0, 0);
        tick();

        // abort mid-RUN; previous result is nonzero so clearing is observable
        run_op(0, 16'h0000, 16'h0001, 1'b0, 1'b0, 0, 0);
        tick();
        op_a = 16'hFFFF; op_b = 16'h0001; op_bin = 1'b0; op_sgn = 1'b0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (2) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_cleared("midrun_reset");
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done_v[0]) done_seen++;
            tick();
        end
        check_eq("aborted_no_done", 32'(done_seen), 32'd0);

        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 20; i++) begin
                run_op(w, 16'($urandom), 16'($urandom), 1'($urandom_range(1)),
                       1'($urandom_range(1)), 0, 0);
                repeat ($urandom_range(1)) tick();
            end
            run_op(w, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0, 0);
            run_op(w, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 0, 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
